// File: rtl/hcordic_pkg.sv
// Shared types and codes for the hyperbolic CORDIC datapath: idle codes, modes,
// requester source ids and the 33-bit float operand layout.
package hcordic_pkg;

    localparam int unsigned SIGN_W    = 1;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MANT_W    = 24;
    localparam int unsigned FLOAT33_W = SIGN_W + EXP_W + MANT_W;
    localparam int unsigned PROD_W    = 50;
    localparam int unsigned IDLE_W    = 2;
    localparam int unsigned STAT_W    = 16;

    localparam logic [IDLE_W-1:0] NO_IDLE     = 2'b00;
    localparam logic [IDLE_W-1:0] ALLIGN_IDLE = 2'b01;
    localparam logic [IDLE_W-1:0] PUT_IDLE    = 2'b10;

    typedef enum logic [1:0] {
        LINEAR     = 2'b00,
        CIRCULAR   = 2'b01,
        HYPERBOLIC = 2'b11
    } mode_e;

    typedef enum logic {
        SRC_X = 1'b0,
        SRC_Y = 1'b1
    } src_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float33_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the requester not granted last wins a contention.
module rr_arbiter2
    import hcordic_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_x,
    input  logic req_y,
    output logic gnt_x_c,
    output logic gnt_y_c
);

    src_e last_grant;

    always_comb begin
        gnt_x_c = 1'b0;
        gnt_y_c = 1'b0;
        if (req_x && (!req_y || last_grant == SRC_Y)) begin
            gnt_x_c = 1'b1;
        end else if (req_y) begin
            gnt_y_c = 1'b1;
        end
    end

    // A grant is always a transfer, since grants go only to valid requesters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= SRC_Y;
        end else if (gnt_x_c) begin
            last_grant <= SRC_X;
        end else if (gnt_y_c) begin
            last_grant <= SRC_Y;
        end
    end

endmodule

// File: rtl/mult_stage_arbiter.sv
// Shares the FP multiply stage between the X and Y CORDIC requesters and routes products back.
// Optional MULT_ARB_STATS_EN adds saturating per-requester grant counters.
module mult_stage_arbiter
    import hcordic_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned TAG_W   = 8
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req_valid_X,
    output logic              req_ready_X,
    input  float33_t          req_a_X,
    input  float33_t          req_b_X,
    input  logic [TAG_W-1:0]  req_tag_X,

    input  logic              req_valid_Y,
    output logic              req_ready_Y,
    input  float33_t          req_a_Y,
    input  float33_t          req_b_Y,
    input  logic [TAG_W-1:0]  req_tag_Y,

    output float33_t          mul_a,
    output float33_t          mul_b,
    output logic [IDLE_W-1:0] mul_idle,
    output logic [TAG_W-1:0]  mul_tag,

    input  logic [IDLE_W-1:0] mul_res_idle,
    input  logic [TAG_W-1:0]  mul_res_tag,
    input  logic [PROD_W-1:0] mul_res_prod,

    output logic              res_valid_X,
    output logic              res_valid_Y,
    output logic [PROD_W-1:0] res_prod,
    output logic [TAG_W-1:0]  res_tag,
    output logic              err
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt_X,
    output logic [STAT_W-1:0] grant_cnt_Y
`endif
);

    localparam int unsigned CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    typedef struct packed {
        logic             v;
        src_e             src;
        logic [TAG_W-1:0] tag;
    } trk_t;

    logic             gnt_x_c;
    logic             gnt_y_c;
    logic             xfer_x_c;
    logic             xfer_y_c;
    src_e             issue_src;
    trk_t [MUL_LAT-1:0] trk;
    trk_t             tail_c;
    logic [CNT_W-1:0] mask_cnt;
    logic             mask_c;
    logic             mismatch_c;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_x   (req_valid_X),
        .req_y   (req_valid_Y),
        .gnt_x_c (gnt_x_c),
        .gnt_y_c (gnt_y_c)
    );

    assign req_ready_X = gnt_x_c;
    assign req_ready_Y = gnt_y_c;
    assign xfer_x_c    = req_valid_X & req_ready_X;
    assign xfer_y_c    = req_valid_Y & req_ready_Y;

    // Issue register: granted operands, or a zeroed bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_tag   <= '0;
            mul_idle  <= PUT_IDLE;
            issue_src <= SRC_X;
        end else if (xfer_x_c) begin
            mul_a     <= req_a_X;
            mul_b     <= req_b_X;
            mul_tag   <= req_tag_X;
            mul_idle  <= NO_IDLE;
            issue_src <= SRC_X;
        end else if (xfer_y_c) begin
            mul_a     <= req_a_Y;
            mul_b     <= req_b_Y;
            mul_tag   <= req_tag_Y;
            mul_idle  <= NO_IDLE;
            issue_src <= SRC_Y;
        end else begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_tag   <= '0;
            mul_idle  <= PUT_IDLE;
            issue_src <= SRC_X;
        end
    end

    // Tracker shifts alongside the multiply pipeline, fed from the issue register,
    // so its tail describes the operation currently on mul_res_*.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trk <= '0;
        end else begin
            trk[0] <= '{v: (mul_idle == NO_IDLE), src: issue_src, tag: mul_tag};
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    assign tail_c      = trk[MUL_LAT-1];
    assign res_valid_X = tail_c.v & (tail_c.src == SRC_X);
    assign res_valid_Y = tail_c.v & (tail_c.src == SRC_Y);
    assign res_prod    = mul_res_prod;
    assign res_tag     = mul_res_tag;

    // The multiply stage is not reset; its stale outputs drain during the mask window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_cnt <= '0;
        end else if (mask_c) begin
            mask_cnt <= mask_cnt + CNT_W'(1);
        end
    end

    assign mask_c     = (mask_cnt != CNT_W'(MUL_LAT));
    assign mismatch_c = tail_c.v ? ((mul_res_idle != NO_IDLE) || (mul_res_tag != tail_c.tag))
                                 : (mul_res_idle == NO_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (mismatch_c && !mask_c) begin
            err <= 1'b1;
        end
    end

`ifdef MULT_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt_X <= '0;
            grant_cnt_Y <= '0;
        end else begin
            if (xfer_x_c && (grant_cnt_X != {STAT_W{1'b1}})) begin
                grant_cnt_X <= grant_cnt_X + STAT_W'(1);
            end
            if (xfer_y_c && (grant_cnt_Y != {STAT_W{1'b1}})) begin
                grant_cnt_Y <= grant_cnt_Y + STAT_W'(1);
            end
        end
    end
`endif

endmodule
